// File: rtl/req_dispatch.sv
// req_dispatch: latches car and hall calls for a 4-storey car, holds the
// travel direction, and presents the effective stop vector and run mode
// to the downstream elevator state controller.
module req_dispatch #(
  parameter int FLOORS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              switch,
  input  logic [FLOORS-1:0] car_btn,
  input  logic [FLOORS-1:0] up_btn,
  input  logic [FLOORS-1:0] dn_btn,
  input  logic [FLOORS-1:0] position,
  input  logic              opendoor,
  input  logic              mv2nxt,
  output logic [FLOORS-1:0] eff_req,
  output logic [1:0]        ud_mode,
  output logic [FLOORS-1:0] car_req,
  output logic [FLOORS-1:0] up_req,
  output logic [FLOORS-1:0] dn_req
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } dir_t;

  localparam logic [FLOORS-1:0] ONE      = {{(FLOORS-1){1'b0}}, 1'b1};
  // No hall-up button exists at the top floor, no hall-down at the ground.
  localparam logic [FLOORS-1:0] UP_VALID = ~(ONE << (FLOORS-1));
  localparam logic [FLOORS-1:0] DN_VALID = ~ONE;

  dir_t              dir_reg, dir_next;
  logic [FLOORS-1:0] car_req_reg, car_req_next;
  logic [FLOORS-1:0] up_req_reg, up_req_next;
  logic [FLOORS-1:0] dn_req_reg, dn_req_next;

  logic              pos_onehot;
  logic [FLOORS-1:0] all_req;
  logic [FLOORS-1:0] above_mask, below_mask;
  logic              above, below;
  logic              clr_en;
  logic [FLOORS-1:0] clr_car, clr_up, clr_dn;

  assign pos_onehot = (position != '0) && ((position & (position - ONE)) == '0);
  assign all_req    = car_req_reg | up_req_reg | dn_req_reg;

  // Floor gi is "above" the car if any position bit lies below gi, and
  // "below" if any position bit lies above gi. Works bitwise for any position.
  for (genvar gi = 0; gi < FLOORS; gi++) begin : g_masks
    assign above_mask[gi] = |(position & ((ONE << gi) - ONE));
    assign below_mask[gi] = |(position & ~((ONE << (gi + 1)) - ONE));
  end

  assign above = |(all_req & above_mask);
  assign below = |(all_req & below_mask);

  // A call is served only at a one-hot floor with the door open; hall calls
  // only when the car leaves in (or is free to take) their direction.
  assign clr_en  = opendoor && pos_onehot;
  assign clr_car = clr_en ? position : '0;
  assign clr_up  = (clr_en && (dir_reg != DOWN)) ? position : '0;
  assign clr_dn  = (clr_en && (dir_reg != UP))   ? position : '0;

  // State registers: request latches and travel direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      car_req_reg <= '0;
      up_req_reg  <= '0;
      dn_req_reg  <= '0;
      dir_reg     <= IDLE;
    end else begin
      car_req_reg <= car_req_next;
      up_req_reg  <= up_req_next;
      dn_req_reg  <= dn_req_next;
      dir_reg     <= dir_next;
    end
  end

  // Next-state: latch presses (clear wins), update direction only when stopped.
  always_comb begin
    car_req_next = (car_req_reg | car_btn) & ~clr_car;
    up_req_next  = (up_req_reg  | up_btn)  & ~clr_up & UP_VALID;
    dn_req_next  = (dn_req_reg  | dn_btn)  & ~clr_dn & DN_VALID;
    dir_next     = dir_reg;
    if (!mv2nxt && pos_onehot) begin
      case (dir_reg)
        IDLE:    dir_next = above ? UP : (below ? DOWN : IDLE);
        UP:      dir_next = above ? UP : (below ? DOWN : IDLE);
        DOWN:    dir_next = below ? DOWN : (above ? UP : IDLE);
        default: dir_next = IDLE;
      endcase
    end
    if (!switch) begin
      car_req_next = '0;
      up_req_next  = '0;
      dn_req_next  = '0;
      dir_next     = IDLE;
    end
  end

  // Effective stops: calls in the travel direction, plus a turnaround stop
  // at the current floor when nothing lies further ahead.
  always_comb begin
    eff_req = all_req;
    case (dir_reg)
      UP:      eff_req = car_req_reg | up_req_reg
                         | (dn_req_reg & position & {FLOORS{~above}});
      DOWN:    eff_req = car_req_reg | dn_req_reg
                         | (up_req_reg & position & {FLOORS{~below}});
      default: eff_req = all_req;
    endcase
  end

  assign ud_mode = dir_reg;
  assign car_req = car_req_reg;
  assign up_req  = up_req_reg;
  assign dn_req  = dn_req_reg;

endmodule

// File: doc/req_dispatch.md
Name: req_dispatch

Overview:
- Request-management stage directly upstream of the elevator state controller, for a 4-storey car.
- Latches in-car and hall call buttons, and holds the travel direction.
- Drives the controller's effective-stop vector `eff_req` and run mode `ud_mode`.
- Consumes the controller's `position`, `opendoor` and `mv2nxt` to clear served calls and to freeze direction while moving.

Parameters:
- FLOORS, 4, number of floors; one bit per floor in every floor vector; bit0 = ground floor.

Ports:
- clk  input  1  system clock, the same high-frequency clock as the state controller.
- rst_n  input  1  asynchronous active-low reset.
- switch  input  1  elevator master switch; 0 = off.
- car_btn  input  FLOORS  in-car floor buttons, level; 1 = pressed.
- up_btn  input  FLOORS  hall up buttons; the top-floor bit is ignored.
- dn_btn  input  FLOORS  hall down buttons; bit0 is ignored.
- position  input  FLOORS  one-hot current floor, from the state controller.
- opendoor  input  1  door-open command, from the state controller.
- mv2nxt  input  1  move command, from the state controller; 1 = travelling.
- eff_req  output  FLOORS  floors at which the car must stop in the current direction.
- ud_mode  output  2  01 = up, 10 = down, 00 = idle; 11 is never driven.
- car_req  output  FLOORS  latched car calls (button lamps).
- up_req  output  FLOORS  latched hall-up calls (lamps).
- dn_req  output  FLOORS  latched hall-down calls (lamps).

Behaviour:
- Reset (rst_n=0, async): car_req, up_req and dn_req = 0; direction register dir = IDLE; ud_mode = 00.
- switch=0 (synchronous, evaluated each clk): all request registers cleared, dir = IDLE, buttons ignored.
- Latching, per clock:
  - req[i] <= (req[i] | btn[i]) & ~clr[i].
  - up_req bit FLOORS-1 and dn_req bit0 are tied to 0.
- Clearing: clr is active only while opendoor=1 and position is one-hot. At the floor p = position:
  - car_req[p] is always cleared.
  - up_req[p] is cleared if dir ∈ {UP, IDLE}.
  - dn_req[p] is cleared if dir ∈ {DOWN, IDLE}.
  - If a button press and a clear hit the same bit in the same cycle, the clear wins: the call is served by the open door.
- Helper terms:
  - all_req = car_req | up_req | dn_req.
  - above = any bit of all_req strictly above p.
  - below = any bit of all_req strictly below p.
- Direction FSM (IDLE/UP/DOWN):
  - Updated on each clk only while mv2nxt=0; frozen while mv2nxt=1.
  - IDLE: above → UP; else below → DOWN; else stay IDLE.
  - UP: above → stay UP; else below → DOWN; else IDLE.
  - DOWN: below → stay DOWN; else above → UP; else IDLE.
  - Ties from IDLE resolve to UP.
  - UP is never entered at the top floor and DOWN never at bit0, because above/below are empty there.
- ud_mode mirrors the registered dir: UP=01, DOWN=10, IDLE=00. It has one cycle of latency from a request change to the mode change.
- eff_req is combinational from the registered state:
  - UP: car_req | up_req, plus dn_req[p] when above=0 (turnaround stop).
  - DOWN: car_req | dn_req, plus up_req[p] when below=0.
  - IDLE: all_req.
- Non-one-hot position (including 0): no clears and dir held; eff_req is still computed bitwise.
- Requests pressed while moving are latched normally. A call at a floor already passed in the current direction is served only after reversal.

Test Plan:
1. rst_n pulse low mid-run with car_req=0100 and dir=UP → car_req/up_req/dn_req = 0 and ud_mode = 00 immediately, without a clock edge.
2. position=0001, idle; car_btn=0100 for 1 cycle → car_req=0100; next cycle ud_mode=01; eff_req=0100.
3. Moving up from 0001 with car_req=1000; dn_btn=0100 pressed → eff_req=1000 (bit2 excluded while UP). At position=1000: dir becomes DOWN, eff_req includes 0100.
4. position=0100, dir=UP, only dn_req=0100 pending; opendoor=1 → dir goes IDLE, dn_req[2] cleared, ud_mode=00.
5. position=0010, opendoor=1, dir=IDLE; car_btn=0010 held → car_req stays 0000 (clear wins). After opendoor=0 with button still held → car_req=0010.
6. All three request vectors nonzero, dir=DOWN, then switch=0 for 1 clk → all requests 0, ud_mode=00 on the following cycle. mv2nxt=1 with new requests above → ud_mode unchanged until mv2nxt=0.
